// File: rtl/sqrt_iter_stage.sv
// Iterative integer square root stage using odd-increment search.
// Accepts a 16-bit radicand, returns floor(sqrt(X)) and (root+1)^2.
module sqrt_iter_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_root,
  output logic [16:0] out_square,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nx;

  logic        live;
  logic [15:0] x;
  logic [16:0] square;
  logic [9:0]  delta;
  logic [7:0]  root;
  logic [7:0]  res_root;
  logic [16:0] res_square;

  logic        accept;
  logic        step;
  logic        finish;

  // live keeps in_ready low until the first edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live <= 1'b0;
    end else begin
      live <= 1'b1;
    end
  end

  assign accept = in_ready && in_valid;
  assign step   = (state == ITER) && (square <= {1'b0, x});
  assign finish = (state == ITER) && !(square <= {1'b0, x});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else if (enable) begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nx = ITER;
        end
      end
      ITER: begin
        if (finish) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = live && (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x      <= 16'd0;
      square <= 17'h00001;
      delta  <= 10'd3;
      root   <= 8'd0;
    end else if (enable) begin
      if (accept) begin
        x      <= in_data;
        square <= 17'h00001;
        delta  <= 10'd3;
        root   <= 8'd0;
      end else if (step) begin
        square <= square + {7'd0, delta};
        delta  <= delta + 10'd2;
        root   <= root + 8'd1;
      end
    end
  end

  // Result copies keep the outputs steady outside DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_root   <= 8'd0;
      res_square <= 17'h00001;
    end else if (enable && finish) begin
      res_root   <= root;
      res_square <= square;
    end
  end

  assign out_root   = res_root;
  assign out_square = res_square;

endmodule

// File: tb/tb_sqrt_iter_stage.sv
// Randomized self-checking bench for sqrt_iter_stage.
// Expected results come from a plain integer square-root model.
module tb_sqrt_iter_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_root;
  logic [16:0] out_square;
  logic        busy;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  logic pending = 1'b0;
  int   exp_root = 0;
  int   exp_sq = 1;
  logic took_hs = 1'b0;
  logic prev_valid = 1'b0;

  sqrt_iter_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_root   (out_root),
    .out_square (out_square),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  function automatic int isqrt(input int v);
    int r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) begin
      passes++;
    end else begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    took_hs = rst_n && out_valid && out_ready && enable;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        check("valid_has_job", int'(pending), 1);
        if (pending) begin
          check("out_root", int'(out_root), exp_root);
          check("out_square", int'(out_square), exp_sq);
        end
        check("in_ready_in_done", int'(in_ready), 0);
        check("busy_in_done", int'(busy), 1);
      end
      if (busy && in_ready) check("ready_while_busy", 1, 0);
      if (prev_valid && !out_valid && !took_hs)
        check("valid_held", 0, 1);
    end
    prev_valid = rst_n && out_valid;
  end

  task automatic run_one(input int xv, input int hold,
                         input int s, input int len, input bit gated);
    int cyc;
    int w;
    int r;
    r = isqrt(xv);
    w = 0;
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) check("wait_in_ready", 0, 1);
    #1;
    exp_root = r;
    exp_sq = (r + 1) * (r + 1);
    pending = 1'b1;
    in_valid = 1'b1;
    in_data = xv[15:0];
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data = 16'($urandom);
    cyc = 1;
    enable = !(len > 0 && cyc >= s && cyc < s + len);
    @(negedge clk);
    while (!out_valid && cyc < 400) begin
      @(posedge clk);
      cyc++;
      #1;
      enable = !(len > 0 && cyc >= s && cyc < s + len);
      in_data = 16'($urandom);
    @(negedge clk);
    end
    enable = 1'b1;
    check("latency", cyc, r + 2 + len);
    if (!out_valid) begin
      pending = 1'b0;
      return;
    end
    repeat (hold) @(negedge clk);
    if (gated) begin
      #1;
      out_ready = 1'b1;
      enable = 1'b0;
      @(posedge clk);
      #1;
      enable = 1'b1;
      @(negedge clk);
      check("gated_handshake_held", int'(out_valid), 1);
    end
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    pending = 1'b0;
    @(negedge clk);
    check("valid_after_hs", int'(out_valid), 0);
    check("ready_after_hs", int'(in_ready), 1);
  endtask

  task automatic abort_run(input int xv, input int at);
    int w;
    w = 0;
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    #1;
    pending = 1'b1;
    exp_root = isqrt(xv);
    exp_sq = (exp_root + 1) * (exp_root + 1);
    in_valid = 1'b1;
    in_data = xv[15:0];
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (at - 1) @(posedge clk);
    #1;
    pending = 1'b0;
    rst_n = 1'b0;
    #1;
    check("abort_valid", int'(out_valid), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_ready", int'(in_ready), 0);
    check("abort_root", int'(dut.root), 0);
    check("abort_square", int'(dut.square), 1);
    check("abort_delta", int'(dut.delta), 3);
    check("abort_x", int'(dut.x), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_ready_back", int'(in_ready), 1);
  endtask

  initial begin
    int xv;
    int r;
    rst_n = 1'b0;
    enable = 1'b1;
    in_valid = 1'b0;
    in_data = 16'd0;
    out_ready = 1'b0;

    check("model_16", isqrt(16), 4);
    check("model_15", isqrt(15), 3);
    check("model_65535", isqrt(65535), 255);
    check("model_40000", isqrt(40000), 200);

    #2;
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_busy", int'(busy), 0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready_clk", int'(in_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("ready_before_edge", int'(in_ready), 0);
    @(negedge clk);
    check("ready_after_edge", int'(in_ready), 1);
    check("idle_busy", int'(busy), 0);

    run_one(0, 0, 0, 0, 1'b0);
    run_one(16, 0, 0, 0, 1'b0);
    run_one(15, 0, 0, 0, 1'b0);
    run_one(65535, 0, 0, 0, 1'b0);
    run_one(100, 10, 0, 0, 1'b1);
    run_one(81, 0, 3, 5, 1'b0);
    abort_run(40000, 50);
    run_one(9, 0, 0, 0, 1'b0);

    for (int i = 0; i < 30; i++) begin
      unique case (i % 3)
        0: xv = int'($urandom_range(0, 65535));
        1: begin
          r = int'($urandom_range(0, 255));
          xv = r * r;
        end
        default: begin
          r = int'($urandom_range(1, 256));
          xv = r * r - 1;
        end
      endcase
      r = isqrt(xv);
      if ($urandom_range(0, 2) == 0)
        run_one(xv, int'($urandom_range(0, 4)),
                int'($urandom_range(1, r + 1)),
                int'($urandom_range(1, 4)), 1'($urandom));
      else
        run_one(xv, int'($urandom_range(0, 4)), 0, 0, 1'($urandom));
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
